// File: rtl/m_key_pkg.sv
// -----------------------------------------------------------------------------
// m_key_pkg
// Shared types and helpers for the push-button front-end (m_key_ctrl and
// m_key_channel).
//   key_state_t : per-key classifier state
//   ms_to_clk() : number of clk cycles in one millisecond
//   max3()      : largest of three durations, used to size the ms counters
// -----------------------------------------------------------------------------
package m_key_pkg;

  typedef enum logic [2:0] {
    KEY_IDLE,
    KEY_DEB_PRS,
    KEY_PRESSED,
    KEY_LONG,
    KEY_DEB_REL
  } key_state_t;

  function automatic int ms_to_clk(input int hz);
    return hz / 1000;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/m_key_ctrl_channel.sv
// -----------------------------------------------------------------------------
// m_key_channel
// One key: 2-flop synchroniser, debounce and short/long/repeat classification.
// Every duration is counted in 1 ms ticks supplied by the parent.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   key_raw    in  raw, unsynchronised button level (polarity per KEY_ACTIVE_LOW)
//   tick       in  1-clk pulse once per millisecond
//   key_first  out 1-clk pulse when a press is accepted
//   key_long   out level, long-press detected until release is accepted
//   key_rep    out 1-clk pulse at long detection and every REPEAT_MS after
// -----------------------------------------------------------------------------
module m_key_channel
  import m_key_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic tick,
  output logic key_first,
  output logic key_long,
  output logic key_rep
);

  localparam int CNT_MAX = max3(LONG_MS, REPEAT_MS, DEBOUNCE_MS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  // Synchroniser, normalised so that 1 means pressed; reset value = released.
  logic sync_p0;
  logic sync_p1;
  logic pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = sync_p1;

  // Classifier state and counters.
  key_state_t       state,    state_nxt;
  logic [CNT_W-1:0] ms_cnt,   ms_cnt_nxt;
  logic [CNT_W-1:0] rel_cnt,  rel_cnt_nxt;
  logic             was_long, was_long_nxt;
  logic             first_nxt;
  logic             long_nxt;
  logic             rep_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KEY_IDLE;
      ms_cnt    <= '0;
      rel_cnt   <= '0;
      was_long  <= 1'b0;
      key_first <= 1'b0;
      key_long  <= 1'b0;
      key_rep   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ms_cnt    <= ms_cnt_nxt;
      rel_cnt   <= rel_cnt_nxt;
      was_long  <= was_long_nxt;
      key_first <= first_nxt;
      key_long  <= long_nxt;
      key_rep   <= rep_nxt;
    end
  end

  // A level change always wins over a coinciding tick: the tick is not
  // counted and the new state starts from zero.
  always_comb begin
    state_nxt    = state;
    ms_cnt_nxt   = ms_cnt;
    rel_cnt_nxt  = rel_cnt;
    was_long_nxt = was_long;
    first_nxt    = 1'b0;
    long_nxt     = key_long;
    rep_nxt      = 1'b0;

    unique case (state)
      KEY_IDLE: begin
        if (pressed) begin
          state_nxt  = KEY_DEB_PRS;
          ms_cnt_nxt = '0;
        end
      end

      KEY_DEB_PRS: begin
        if (!pressed) begin
          state_nxt  = KEY_IDLE;
          ms_cnt_nxt = '0;
        end else if (tick) begin
          if (ms_cnt == DEB_LAST) begin
            state_nxt  = KEY_PRESSED;
            first_nxt  = 1'b1;
            ms_cnt_nxt = '0;
          end else begin
            ms_cnt_nxt = ms_cnt + 1'b1;
          end
        end
      end

      KEY_PRESSED: begin
        if (!pressed) begin
          state_nxt    = KEY_DEB_REL;
          was_long_nxt = 1'b0;
          rel_cnt_nxt  = '0;
        end else if (tick) begin
          if (ms_cnt == LONG_LAST) begin
            state_nxt  = KEY_LONG;
            long_nxt   = 1'b1;
            rep_nxt    = 1'b1;
            ms_cnt_nxt = '0;
          end else begin
            ms_cnt_nxt = ms_cnt + 1'b1;
          end
        end
      end

      KEY_LONG: begin
        if (!pressed) begin
          state_nxt    = KEY_DEB_REL;
          was_long_nxt = 1'b1;
          rel_cnt_nxt  = '0;
        end else if (tick) begin
          if (ms_cnt == REP_LAST) begin
            rep_nxt    = 1'b1;
            ms_cnt_nxt = '0;
          end else begin
            ms_cnt_nxt = ms_cnt + 1'b1;
          end
        end
      end

      // ms_cnt is frozen here so a short release gap resumes the hold/repeat
      // timing where it stopped; key_long stays up until release is accepted.
      KEY_DEB_REL: begin
        if (pressed) begin
          state_nxt = was_long ? KEY_LONG : KEY_PRESSED;
        end else if (tick) begin
          if (rel_cnt == DEB_LAST) begin
            state_nxt    = KEY_IDLE;
            long_nxt     = 1'b0;
            rel_cnt_nxt  = '0;
            ms_cnt_nxt   = '0;
            was_long_nxt = 1'b0;
          end else begin
            rel_cnt_nxt = rel_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = KEY_IDLE;
        long_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/m_key_ctrl.sv
// -----------------------------------------------------------------------------
// m_key_ctrl
// Push-button front-end: synchronises, debounces and classifies NUM_KEYS raw
// inputs into short-press pulses, long-press levels and auto-repeat pulses.
// Holds the shared millisecond tick; each key is handled by m_key_channel.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   key_raw    in  [NUM_KEYS] raw button levels (polarity per KEY_ACTIVE_LOW)
//   key_first  out [NUM_KEYS] 1-clk pulse when a press is accepted
//   key_long   out [NUM_KEYS] high from long-press detection until release accepted
//   key_rep    out [NUM_KEYS] 1-clk pulse at long detection, then every REPEAT_MS
// -----------------------------------------------------------------------------
module m_key_ctrl
  import m_key_pkg::*;
#(
  parameter int NUM_KEYS       = 2,
  parameter int IN_CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_first,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_rep
);

  localparam int CLK_PER_MS = ms_to_clk(IN_CLK_HZ);
  localparam int TICK_W     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_MS - 1);

  // Free-running millisecond divider; tick marks the wrap.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    m_key_channel #(
      .DEBOUNCE_MS   (DEBOUNCE_MS),
      .LONG_MS       (LONG_MS),
      .REPEAT_MS     (REPEAT_MS),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (key_raw[k]),
      .tick     (tick),
      .key_first(key_first[k]),
      .key_long (key_long[k]),
      .key_rep  (key_rep[k])
    );
  end

endmodule

// File: tb/tb_m_key_ctrl.sv
`timescale 1ns/1ps
module tb_m_key_ctrl;

  localparam int NK      = 2;
  localparam int CLK_MS  = 10;     // IN_CLK_HZ = 10_000
  localparam int DEB     = 20;
  localparam int LONG_MS = 1000;
  localparam int REP_MS  = 200;

  localparam int EV_FIRST = 0;
  localparam int EV_LRISE = 1;
  localparam int EV_REP   = 2;
  localparam int EV_LFALL = 3;

  typedef struct {int kind; int t; int g;} ev_t;
  typedef struct {bit lvl; int dur;} seg_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_first;
  logic [NK-1:0] key_long;
  logic [NK-1:0] key_rep;

  m_key_ctrl #(
    .NUM_KEYS(NK), .IN_CLK_HZ(10_000), .DEBOUNCE_MS(DEB),
    .LONG_MS(LONG_MS), .REPEAT_MS(REP_MS), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
    .key_first(key_first), .key_long(key_long), .key_rep(key_rep)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int start = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seg_t seg   [NK][$];
  ev_t  exp_q [NK][$];
  ev_t  act_q [NK][$];
  bit   amb;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ev_t mk(input int kind, input int t, input int g);
    ev_t e;
    e.kind = kind; e.t = t; e.g = g;
    return e;
  endfunction

  // Event recorder, sampled on the falling edge.
  logic [NK-1:0] long_prev = '0;
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (key_long[k] && !long_prev[k]) act_q[k].push_back(mk(EV_LRISE, cyc - start, 0));
      if (!key_long[k] && long_prev[k]) act_q[k].push_back(mk(EV_LFALL, cyc - start, 0));
      if (key_rep[k])   act_q[k].push_back(mk(EV_REP, cyc - start, 0));
      if (key_first[k]) act_q[k].push_back(mk(EV_FIRST, cyc - start, 0));
    end
    long_prev = key_long;
  end

  // Reference model: walks the press/release segments (in ms) and predicts
  // the output events from the key rules. held = accumulated pressed time
  // since acceptance (release gaps excluded); gaps = short release gaps since
  // acceptance, each widening the timing tolerance by 1 ms.
  function automatic void run_model(input int k);
    int t = 0, c, r, te, d, held = 0, nxt = LONG_MS, gaps = 0;
    bit acc = 0, lng = 0;
    exp_q[k].delete();
    for (int i = 0; i < seg[k].size(); i++) begin
      d = seg[k][i].dur;
      if (seg[k][i].lvl) begin
        c = t; r = d;
        if (!acc) begin
          if (d > DEB - 3 && d < DEB + 3) amb = 1;
          if (d >= DEB) begin
            acc = 1; lng = 0; held = 0; nxt = LONG_MS; gaps = 0;
            exp_q[k].push_back(mk(EV_FIRST, t + DEB, 0));
            c = t + DEB; r = d - DEB;
          end
        end
        if (acc) begin
          while (held + r >= nxt) begin
            te = c + (nxt - held);
            r  = r - (nxt - held);
            c  = te; held = nxt;
            if (!lng) begin
              exp_q[k].push_back(mk(EV_LRISE, te, gaps));
              lng = 1;
            end
            exp_q[k].push_back(mk(EV_REP, te, gaps));
            nxt = nxt + REP_MS;
            if (t + d - te < 2 + gaps) amb = 1;
          end
          held = held + r;
          if (nxt - held < 2 + gaps) amb = 1;
        end
      end else if (acc) begin
        if (d > DEB - 3 && d < DEB + 3) amb = 1;
        if (d >= DEB) begin
          acc = 0;
          if (lng) exp_q[k].push_back(mk(EV_LFALL, t + DEB, 0));
          lng = 0;
        end else begin
          gaps++;
        end
      end
      t = t + d;
    end
  endfunction

  function automatic bit level_at(input int k, input int ms);
    int acc_t = 0;
    for (int i = 0; i < seg[k].size(); i++) begin
      if (ms < acc_t + seg[k][i].dur) return seg[k][i].lvl;
      acc_t = acc_t + seg[k][i].dur;
    end
    return 1'b0;
  endfunction

  task automatic add_seg(input int k, input bit lvl, input int dur);
    seg_t s;
    s.lvl = lvl; s.dur = dur;
    seg[k].push_back(s);
  endtask

  task automatic clear_segs();
    for (int k = 0; k < NK; k++) seg[k].delete();
  endtask

  // Drives the segment lists (active-low pins) 1 ms at a time.
  task automatic play(input bit release_at_end);
    int tmax = 0, len;
    for (int k = 0; k < NK; k++) begin
      len = 0;
      for (int i = 0; i < seg[k].size(); i++) len = len + seg[k][i].dur;
      if (len > tmax) tmax = len;
      run_model(k);
    end
    for (int k = 0; k < NK; k++) act_q[k].delete();
    @(posedge clk); #1;
    start = cyc;
    for (int ms = 0; ms < tmax; ms++) begin
      for (int k = 0; k < NK; k++) key_raw[k] = ~level_at(k, ms);
      repeat (CLK_MS) @(posedge clk);
      #1;
    end
    if (release_at_end) key_raw = '1;
  endtask

  task automatic gen_segs(input int k);
    int total = 0, d;
    seg[k].delete();
    while (total < 300) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(2, 14);
        1, 2:    d = $urandom_range(26, 300);
        default: d = $urandom_range(600, 900);
      endcase
      add_seg(k, 1, d); total = total + d;
      d = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 14) : $urandom_range(26, 80);
      add_seg(k, 0, d); total = total + d;
    end
    add_seg(k, 0, 60);
  endtask

  task automatic test_reset();
    key_raw = '0;
    #2 rst_n = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (key_first !== 2'b00) begin n_bad++; $display("FAIL reset key_first: got %b want 00", key_first); end
    n_cmp++; if (key_long  !== 2'b00) begin n_bad++; $display("FAIL reset key_long: got %b want 00", key_long); end
    n_cmp++; if (key_rep   !== 2'b00) begin n_bad++; $display("FAIL reset key_rep: got %b want 00", key_rep); end
    key_raw = '1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < NK; k++) act_q[k].delete();
    repeat (300) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== 0) begin
        n_bad++; $display("FAIL reset_idle key%0d events: got %0d want 0", k, act_q[k].size());
      end
    end
  endtask

  task automatic test_clean_press();
    clear_segs();
    add_seg(0, 1, 50); add_seg(0, 0, 60);
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL clean_press key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL clean_press key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
  endtask

  task automatic test_bounce();
    clear_segs();
    for (int j = 0; j < 3; j++) begin add_seg(0, 1, 3); add_seg(0, 0, 3); end
    add_seg(0, 1, 100); add_seg(0, 0, 60);
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL bounce key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL bounce key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
  endtask

  task automatic test_long_hold();
    clear_segs();
    add_seg(0, 1, 1500); add_seg(0, 0, 60);
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL long_hold key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL long_hold key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
  endtask

  task automatic test_glitch_gap();
    clear_segs();
    add_seg(0, 1, 15);   add_seg(0, 0, 40);
    add_seg(0, 1, 1050); add_seg(0, 0, 10);
    add_seg(0, 1, 200);  add_seg(0, 0, 60);
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL glitch_gap key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL glitch_gap key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
  endtask

  task automatic test_both_keys();
    clear_segs();
    for (int k = 0; k < NK; k++) begin add_seg(k, 1, 1200); add_seg(k, 0, 60); end
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL both_keys key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL both_keys key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
    // identical stimulus on both pins: every event must land on the same clk
    for (int i = 0; i < act_q[0].size() && i < act_q[1].size(); i++) begin
      n_cmp++;
      if (act_q[1][i].t !== act_q[0][i].t || act_q[1][i].kind !== act_q[0][i].kind) begin
        n_bad++; $display("FAIL both_keys same_cycle ev%0d: key1 kind %0d @%0d, key0 kind %0d @%0d", i,
                          act_q[1][i].kind, act_q[1][i].t, act_q[0][i].kind, act_q[0][i].t);
      end
    end
  endtask

  task automatic test_reset_in_long();
    clear_segs();
    add_seg(0, 1, 1040);
    play(0);
    for (int i = 0; i < act_q[0].size() && i < exp_q[0].size(); i++) begin
      int dt = act_q[0][i].t - exp_q[0][i].t * CLK_MS;
      n_cmp++;
      if (act_q[0][i].kind !== exp_q[0][i].kind || dt < -8 || dt > 5) begin
        n_bad++; $display("FAIL pre_reset ev%0d: got kind %0d @%0d want kind %0d @%0d", i,
                          act_q[0][i].kind, act_q[0][i].t, exp_q[0][i].kind, exp_q[0][i].t * CLK_MS);
      end
    end
    n_cmp++;
    if (key_long !== 2'b01) begin n_bad++; $display("FAIL pre_reset key_long: got %b want 01", key_long); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (key_long !== 2'b00) begin n_bad++; $display("FAIL async_reset key_long: got %b want 00", key_long); end
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_segs();
    add_seg(0, 1, 100); add_seg(0, 0, 60);
    play(1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (act_q[k].size() !== exp_q[k].size()) begin
        n_bad++; $display("FAIL post_reset key%0d count: got %0d want %0d", k, act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
        n_cmp++;
        if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
          n_bad++; $display("FAIL post_reset key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", k, i,
                            act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      int tries = 0;
      do begin
        amb = 0;
        for (int k = 0; k < NK; k++) begin gen_segs(k); run_model(k); end
        tries++;
      end while (amb && tries < 50);
      if (amb) begin
        clear_segs();
        for (int k = 0; k < NK; k++) begin add_seg(k, 1, 60 + 40*k); add_seg(k, 0, 60); end
      end
      play(1);
      for (int k = 0; k < NK; k++) begin
        n_cmp++;
        if (act_q[k].size() !== exp_q[k].size()) begin
          n_bad++; $display("FAIL random%0d key%0d count: got %0d want %0d", it, k, act_q[k].size(), exp_q[k].size());
        end
        for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
          int dt = act_q[k][i].t - exp_q[k][i].t * CLK_MS;
          n_cmp++;
          if (act_q[k][i].kind !== exp_q[k][i].kind || dt < -8 - 10*exp_q[k][i].g || dt > 5 + 10*exp_q[k][i].g) begin
            n_bad++; $display("FAIL random%0d key%0d ev%0d: got kind %0d @%0d want kind %0d @%0d", it, k, i,
                              act_q[k][i].kind, act_q[k][i].t, exp_q[k][i].kind, exp_q[k][i].t * CLK_MS);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_glitch_gap();
    test_both_keys();
    test_reset_in_long();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
